// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-to-1 TDM multiplexer: lane count, slot
// select width and FSM state encoding.
package tdm_pkg;
  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tdm_state_t;
endpackage

// File: rtl/tdm_slot_timer.sv
// Slot timer for the TDM multiplexer: counts cycles within a slot and the
// slot index within a frame. Held at slot 0 / cycle 0 while not active, so
// the first active cycle is always the first cycle of slot 0.
module tdm_slot_timer
  import tdm_pkg::*;
#(
  parameter int SLOT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active,
  output logic [SEL_W-1:0] slot,
  output logic             slot_last,
  output logic             frame_last
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [SEL_W-1:0] SLOT_MAX = SEL_W'(NUM_LANES - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [SEL_W-1:0] slot_reg;

  assign slot       = slot_reg;
  assign slot_last  = (cnt_reg == CNT_MAX);
  assign frame_last = slot_last && (slot_reg == SLOT_MAX);

  // Cycle counter wraps at CNT_MAX and advances the slot; the 2-bit slot
  // index wraps 3->0 exactly on the frame's last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      slot_reg <= '0;
    end else if (!active) begin
      cnt_reg  <= '0;
      slot_reg <= '0;
    end else if (slot_last) begin
      cnt_reg  <= '0;
      slot_reg <= slot_reg + 1'b1;
    end else begin
      cnt_reg  <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/tdm_mux_4x1.sv
// Clocked 4-to-1 time-division multiplexer. Snapshots four lanes at each
// frame boundary and sends them out one lane per slot, with matching slot
// select and a frame-start strobe. All outputs are registered.
// Optional feature: define TDM_MUX_PARITY_EN to add the `parity` output
// (XOR of the four snapshotted lanes, held for the frame).
module tdm_mux_4x1
  import tdm_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int SLOT_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_LANES*WIDTH-1:0] in,
  output logic [WIDTH-1:0]           out,
  output logic [SEL_W-1:0]           sel,
  output logic                       valid,
`ifdef TDM_MUX_PARITY_EN
  output logic                       frame_start,
  output logic [WIDTH-1:0]           parity
`else
  output logic                       frame_start
`endif
);

  tdm_state_t       state_reg;
  logic [WIDTH-1:0] in_lane  [NUM_LANES];
  logic [WIDTH-1:0] snap_reg [NUM_LANES];
  logic [WIDTH-1:0] out_reg;
  logic             valid_reg;
  logic             frame_start_reg;
  logic             slot_last;
  logic             frame_last;
  logic             capture;
  logic [SEL_W-1:0] next_slot;

  tdm_slot_timer #(
    .SLOT_CYCLES(SLOT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (state_reg == RUN),
    .slot      (sel),
    .slot_last (slot_last),
    .frame_last(frame_last)
  );

  // A new frame begins either from IDLE or at the boundary of a running frame.
  assign capture   = en && ((state_reg == IDLE) || frame_last);
  assign next_slot = sel + 1'b1;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign in_lane[gi] = in[gi*WIDTH +: WIDTH];

    // Lane snapshot, refreshed only when a frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        snap_reg[gi] <= '0;
      end else if (capture) begin
        snap_reg[gi] <= in_lane[gi];
      end
    end
  end

  // FSM with registered outputs; lane 0 comes straight from `in` on the
  // capture edge because the snapshot is being written at that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      out_reg         <= '0;
      valid_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (en) begin
            state_reg       <= RUN;
            out_reg         <= in_lane[0];
            valid_reg       <= 1'b1;
            frame_start_reg <= 1'b1;
          end else begin
            out_reg         <= '0;
            valid_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
          end
        end
        RUN: begin
          frame_start_reg <= 1'b0;
          if (frame_last) begin
            if (en) begin
              out_reg         <= in_lane[0];
              frame_start_reg <= 1'b1;
            end else begin
              state_reg <= IDLE;
              out_reg   <= '0;
              valid_reg <= 1'b0;
            end
          end else if (slot_last) begin
            out_reg <= snap_reg[next_slot];
          end
        end
        default: begin
          state_reg       <= IDLE;
          out_reg         <= '0;
          valid_reg       <= 1'b0;
          frame_start_reg <= 1'b0;
        end
      endcase
    end
  end

  assign out         = out_reg;
  assign valid       = valid_reg;
  assign frame_start = frame_start_reg;

`ifdef TDM_MUX_PARITY_EN
  logic [WIDTH-1:0] parity_reg;
  logic [WIDTH-1:0] in_par;

  assign in_par = in_lane[0] ^ in_lane[1] ^ in_lane[2] ^ in_lane[3];

  // Parity follows the snapshot and is cleared when the block drops to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_reg <= '0;
    end else if (capture) begin
      parity_reg <= in_par;
    end else if ((state_reg == RUN) && frame_last) begin
      parity_reg <= '0;
    end
  end

  assign parity = parity_reg;
`endif

endmodule

// File: tb/tb_tdm_mux_4x1.sv
// Scoreboard bench for tdm_mux_4x1: two instances (SLOT_CYCLES 1 and 3)
// share stimulus; a frame-level model queues the expected output of every
// cycle and a negedge monitor pops and compares.
module tb_tdm_mux_4x1;
  localparam int W = 2;
  localparam int SCV [2] = '{1, 3};
`ifdef TDM_MUX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]   sel;
    logic [W-1:0] dout;
    logic         valid;
    logic         fs;
    logic [W-1:0] par;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [4*W-1:0] din = '0;

  logic [W-1:0] out0, out1, par0, par1;
  logic [1:0]   sel0, sel1;
  logic         valid0, valid1, fs0, fs1;

  obs_t q [2][$];
  int   rem [2];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  tdm_mux_4x1 #(.WIDTH(W), .SLOT_CYCLES(SCV[0])) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(din), .out(out0), .sel(sel0),
`ifdef TDM_MUX_PARITY_EN
    .valid(valid0), .frame_start(fs0), .parity(par0)
`else
    .valid(valid0), .frame_start(fs0)
`endif
  );

  tdm_mux_4x1 #(.WIDTH(W), .SLOT_CYCLES(SCV[1])) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(din), .out(out1), .sel(sel1),
`ifdef TDM_MUX_PARITY_EN
    .valid(valid1), .frame_start(fs1), .parity(par1)
`else
    .valid(valid1), .frame_start(fs1)
`endif
  );

`ifndef TDM_MUX_PARITY_EN
  assign par0 = '0;
  assign par1 = '0;
`endif

  function automatic obs_t get_act(int d);
    obs_t a;
    if (d == 0) a = '{sel: sel0, dout: out0, valid: valid0, fs: fs0, par: par0};
    else        a = '{sel: sel1, dout: out1, valid: valid1, fs: fs1, par: par1};
    return a;
  endfunction

  // Frame-level model: when a frame starts, queue its whole 4*SC-cycle output.
  task automatic model_step(int d);
    obs_t         e;
    logic [4*W-1:0] v;
    logic [W-1:0] p;
    int           sc;
    sc = SCV[d];
    if (rem[d] > 0) begin
      rem[d]--;
    end else if (en) begin
      v = din;
      p = '0;
      for (int i = 0; i < 4; i++) p ^= v[i*W +: W];
      for (int k = 0; k < 4*sc; k++) begin
        e.sel   = 2'(k / sc);
        e.dout  = v[(k/sc)*W +: W];
        e.valid = 1'b1;
        e.fs    = (k == 0);
        e.par   = PAR_ON ? p : '0;
        q[d].push_back(e);
      end
      rem[d] = 4*sc - 1;
    end else begin
      q[d].push_back(obs_t'(0));
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        q[d].delete();
        rem[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  // Monitor: one comparison per instance per cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      obs_t a, e;
      a = get_act(d);
      checks++;
      if (!rst_n) begin
        e = obs_t'(0);
      end else if (q[d].size() == 0) begin
        errors++;
        $display("FAIL dut%0d underflow: no expected entry at %0t", d, $time);
        continue;
      end else begin
        e = q[d].pop_front();
      end
      if (a != e) begin
        errors++;
        $display("FAIL dut%0d cycle@%0t: got sel=%0d out=%h valid=%b fs=%b par=%h, expected sel=%0d out=%h valid=%b fs=%b par=%h",
                 d, $time, a.sel, a.dout, a.valid, a.fs, a.par, e.sel, e.dout, e.valid, e.fs, e.par);
      end else begin
        $display("ok dut%0d t=%0t sel=%0d out=%h valid=%b fs=%b par=%h", d, $time, a.sel, a.dout, a.valid, a.fs, a.par);
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset held through two cycles, released between edges.
    cycles(2);
    #2 rst_n = 1'b1;

    // Lanes 01,11,00,10 held with en=1 (parity 00), then lane3 -> 11 (parity 01).
    @(negedge clk);
    en  = 1'b1;
    din = 8'b10_00_11_01;
    cycles(24);
    din = 8'b11_00_11_01;
    cycles(24);

    // en dropped: both instances finish their frame then go idle.
    en = 1'b0;
    cycles(16);

    // Asynchronous reset mid-frame, checked before the next clock edge.
    en  = 1'b1;
    din = 8'b01_10_11_00;
    cycles(7);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      obs_t a;
      a = get_act(d);
      checks++;
      if (a != obs_t'(0)) begin
        errors++;
        $display("FAIL dut%0d async_reset: got %h, expected 0", d, a);
      end else begin
        $display("ok dut%0d async_reset outputs zero", d);
      end
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    cycles(20);

    // Randomised lanes every cycle with en density varied per burst.
    for (int b = 0; b < 12; b++) begin
      int thr;
      thr = $urandom_range(0, 10);
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        din = W'(0) | 8'($urandom);
        en  = ($urandom_range(0, 9) < thr);
      end
    end
    en = 1'b0;
    cycles(16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdm_mux_4x1.md
# tdm_mux_4x1

Clocked 4-to-1 time-division multiplexer: snapshots four parallel lanes at each frame boundary and presents them one lane per slot on a single output. It also emits the matching 2-bit slot select and a frame-start strobe. It is the transmit end of the team's 1-to-4 demultiplexer path: `out` drives the demux data input and `sel` drives its select, so lane i reappears on demux output i.

## Interface
- `WIDTH`, default 1: bits per lane.
- `SLOT_CYCLES`, default 1: clock cycles each slot is held; legal values ≥ 1.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `en`, input, 1: request to transmit frames.
- `in`, input, 4*WIDTH: lane i is `in[i*WIDTH +: WIDTH]`.
- `out`, output, WIDTH: current slot's snapshotted lane data.
- `sel`, output, 2: current slot index 0..3.
- `valid`, output, 1: high while a frame is being transmitted.
- `frame_start`, output, 1: one-cycle pulse in the first cycle of slot 0.
- `parity`, output, WIDTH: present only with `TDM_MUX_PARITY_EN`.

## Operation
- States: IDLE, RUN. Reset value is IDLE.
- In IDLE: `out`=0, `sel`=0, `valid`=0, `frame_start`=0, `parity`=0.
- IDLE → RUN on an edge where `en`=1. At that edge:
  - all four lanes are captured into the snapshot register;
  - slot=0, slot-cycle counter=0.
- In RUN:
  - `out` = snapshot lane `sel`;
  - `valid`=1;
  - slot-cycle counter counts 0..SLOT_CYCLES-1, then `sel` increments.
- Frame boundary is the last cycle of slot 3:
  - `en`=1: re-snapshot `in` and continue at slot 0 with no gap cycle.
  - `en`=0: return to IDLE.
- `en` deasserting mid-frame never truncates the frame. The current frame always completes all 4 slots.
- `in` changes mid-frame have no effect until the next snapshot.
- `sel` wraps 3→0 only at a frame boundary. It never exceeds 3.
- Counter width is max(1, $clog2(SLOT_CYCLES)). The counter never reaches SLOT_CYCLES.

## Timing
- All outputs are registered. No combinational path from `in` or `en` to any output.
- Latency: `en` high before edge k (in IDLE) → after edge k, `sel`=0, `valid`=1, `frame_start`=1, `out`=snapshot lane 0 (`in` value at edge k).
- Frame length is exactly 4*SLOT_CYCLES cycles. Back-to-back frames have `frame_start` pulses exactly that far apart.
- `rst_n` low at any time, including mid-slot: all outputs go to their reset values immediately (asynchronously), state goes to IDLE, and the snapshot is cleared.
- After `rst_n` deasserts: the first edge with `en`=1 starts a fresh frame at slot 0.

## Configuration
- `TDM_MUX_PARITY_EN` defined:
  - `parity` port exists.
  - `parity` = lane0^lane1^lane2^lane3 of the snapshot, registered at the same edge as the snapshot.
  - Held for the whole frame; 0 in IDLE.
- `TDM_MUX_PARITY_EN` not defined: no `parity` port and no parity logic. All other behaviour is identical.

## Structure
- Package `tdm_pkg`:
  - `NUM_LANES`=4;
  - `SEL_W`=2;
  - state enum `tdm_state_t` {IDLE, RUN}.
- Sub-module `tdm_slot_timer`:
  - slot-cycle counter plus slot index;
  - outputs `slot_last` (last cycle of a slot) and `frame_last` (last cycle of slot 3).
- Top level holds the FSM, the snapshot register, the output muxing and the optional parity.

## Test plan
- WIDTH=1, SLOT_CYCLES=1, `in`=4'b0110, `en` held 1 → `out` 0,1,1,0 with `sel` 0,1,2,3, `frame_start` on the `sel`=0 cycle. The frame repeats with no gap.
- Same config, `in` changed to 4'b1111 during slot 1 → current frame still ends 1,0. Next frame is 1,1,1,1.
- `en` dropped during slot 1 → slots 2 and 3 still output. Next cycle `valid`=0, `sel`=0, `out`=0.
- SLOT_CYCLES=3, `in`=4'b1001 → each slot held 3 cycles. `frame_start` pulses are 12 cycles apart, sequence 1,1,1,0,0,0,0,0,0,1,1,1.
- `rst_n` pulsed low mid-slot 2 → outputs zero without waiting for a clock edge. After release with `en`=1, restart at `sel`=0 with `frame_start`=1.
- `TDM_MUX_PARITY_EN`, WIDTH=2, lanes 2'b01, 2'b11, 2'b00, 2'b10 → `parity`=2'b00 for the whole frame. With lane3 changed to 2'b11 → next frame `parity`=2'b01.
